// File: rtl/rrp_mult_sched_if.sv
// rrp_mult_sched_if: requester, multiplier and result signals of rrp_mult_sched.
// The slave modport is the scheduler; master is the surrounding system.
interface rrp_mult_sched_if #(
  parameter int WIDTH = 7,
  parameter int RADIX = 2,
  parameter int NREQ  = 4
);
  localparam int D   = $clog2(RADIX) + 1;
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*D*WIDTH-1:0]   req_x;
  logic [NREQ*D*WIDTH-1:0]   req_y;
  logic [D*WIDTH-1:0]        mult_x;
  logic [D*WIDTH-1:0]        mult_y;
  logic [D*(2*WIDTH+1)-1:0]  mult_p;
  logic                      res_valid;
  logic                      res_ready;
  logic [IDW-1:0]            res_id;
  logic [D*(2*WIDTH+1)-1:0]  res_p;
  modport slave (
    input  req_valid, req_x, req_y, mult_p, res_ready,
    output req_ready, mult_x, mult_y, res_valid, res_id, res_p
  );
  modport master (
    output req_valid, req_x, req_y, mult_p, res_ready,
    input  req_ready, mult_x, mult_y, res_valid, res_id, res_p
  );
endinterface

// File: rtl/rrp_mult_sched.sv
// rrp_mult_sched: round-robin sharing of one non-stallable online multiplier across NREQ requesters.
// Define RRP_MULT_SCHED_PERF_EN to add the issue/stall performance counters.
module rrp_mult_sched #(
  parameter int WIDTH      = 7,
  parameter int RADIX      = 2,
  parameter int NREQ       = 4,
  parameter int MULT_LAT   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic i_clock,
  input  logic i_reset_n,
`ifdef RRP_MULT_SCHED_PERF_EN
  output logic [31:0] o_issue_count,
  output logic [31:0] o_stall_count,
`endif
  rrp_mult_sched_if.slave io_bus
);
  localparam int D   = $clog2(RADIX) + 1;
  localparam int DW  = D * WIDTH;
  localparam int PRW = D * (2 * WIDTH + 1);
  localparam int IDW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int AW  = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + MULT_LAT + 1) + 1;
  logic [IDW-1:0] r_ptr, w_gnt_id, w_idx;
  logic [IDW:0]   w_sum;
  logic           w_any, w_issue, w_pop, w_push, w_credit;
  logic [MULT_LAT-1:0] r_tag_v;
  logic [IDW-1:0] r_tag_id [MULT_LAT];
  logic [CW-1:0]  r_count, r_inflight;
  logic [AW-1:0]  r_wr, r_rd;
  logic [PRW-1:0] r_mem_p [FIFO_DEPTH];
  logic [IDW-1:0] r_mem_id [FIFO_DEPTH];
  // scan downward so the valid requester closest to r_ptr wins
  always_comb begin
    w_gnt_id = '0;
    w_any    = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      w_idx = IDW'(w_sum >= (IDW+1)'(NREQ) ? w_sum - (IDW+1)'(NREQ) : w_sum);
      if (io_bus.req_valid[w_idx]) begin
        w_gnt_id = w_idx;
        w_any    = 1'b1;
      end
    end
  end
  // in-flight tags reserve FIFO space; a pop this cycle frees its slot immediately
  assign w_credit          = r_count + r_inflight - CW'(w_pop) < CW'(FIFO_DEPTH);
  assign w_issue           = i_reset_n & w_any & w_credit;
  assign w_push            = r_tag_v[MULT_LAT-1];
  assign w_pop             = io_bus.res_valid & io_bus.res_ready;
  assign io_bus.req_ready  = w_issue ? NREQ'(1) << w_gnt_id : '0;
  assign io_bus.mult_x     = w_issue ? io_bus.req_x[w_gnt_id*DW +: DW] : '0;
  assign io_bus.mult_y     = w_issue ? io_bus.req_y[w_gnt_id*DW +: DW] : '0;
  assign io_bus.res_valid  = r_count != '0;
  assign io_bus.res_p      = io_bus.res_valid ? r_mem_p[r_rd] : '0;
  assign io_bus.res_id     = io_bus.res_valid ? r_mem_id[r_rd] : '0;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      r_ptr      <= '0;
      r_tag_v    <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      for (int i = 0; i < MULT_LAT; i++) r_tag_id[i] <= '0;
    end else begin
      if (w_issue) r_ptr <= w_gnt_id == IDW'(NREQ - 1) ? '0 : w_gnt_id + 1'b1;
      r_tag_v[0]  <= w_issue;
      r_tag_id[0] <= w_gnt_id;
      for (int i = 1; i < MULT_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr <= r_wr == AW'(FIFO_DEPTH - 1) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == AW'(FIFO_DEPTH - 1) ? '0 : r_rd + 1'b1;
    end
  always_ff @(posedge i_clock)
    if (w_push) begin
      r_mem_p[r_wr]  <= io_bus.mult_p;
      r_mem_id[r_wr] <= r_tag_id[MULT_LAT-1];
    end
`ifdef RRP_MULT_SCHED_PERF_EN
  logic [31:0] r_issue_count, r_stall_count;
  always_ff @(posedge i_clock or negedge i_reset_n)
    if (!i_reset_n) begin
      r_issue_count <= '0;
      r_stall_count <= '0;
    end else begin
      r_issue_count <= r_issue_count + 32'(w_issue);
      r_stall_count <= r_stall_count + 32'(|io_bus.req_valid & ~w_credit);
    end
  assign o_issue_count = r_issue_count;
  assign o_stall_count = r_stall_count;
`else
`endif
endmodule

// File: tb/tb_rrp_mult_sched.sv
// tb_rrp_mult_sched: directed checks of rrp_mult_sched with a two-stage registered multiplier stand-in.
module tb_rrp_mult_sched;
  localparam int WIDTH = 7, RADIX = 2, NREQ = 4, MULT_LAT = 2, FIFO_DEPTH = 4;
  localparam int DW = 14, PW = 30;
  typedef struct { logic [1:0] id; logic [PW-1:0] p; } res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ox [NREQ];
  logic [DW-1:0] oy [NREQ];
  logic [DW-1:0] m_x, m_y;
  logic [PW-1:0] m_p;
`ifdef RRP_MULT_SCHED_PERF_EN
  logic [31:0] issue_count, stall_count;
`endif
  rrp_mult_sched_if #(.WIDTH(WIDTH), .RADIX(RADIX), .NREQ(NREQ)) bus ();
  rrp_mult_sched #(.WIDTH(WIDTH), .RADIX(RADIX), .NREQ(NREQ), .MULT_LAT(MULT_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clock(clk),
    .i_reset_n(rst_n),
`ifdef RRP_MULT_SCHED_PERF_EN
    .o_issue_count(issue_count),
    .o_stall_count(stall_count),
`endif
    .io_bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [PW-1:0] mp(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return PW'(x) * PW'(y);
  endfunction
  // multiplier stand-in: registered inputs, registered product, two edges total
  always @(posedge clk) begin
    m_x <= bus.mult_x;
    m_y <= bus.mult_y;
    m_p <= mp(m_x, m_y);
  end
  assign bus.mult_p = m_p;
  task automatic drive(input logic [NREQ-1:0] v, input logic rr);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[i*DW +: DW] = ox[i];
      bus.req_y[i*DW +: DW] = oy[i];
    end
    bus.req_valid = v;
    bus.res_ready = rr;
  endtask
  task automatic step(input logic [NREQ-1:0] v, input logic rr);
    @(posedge clk);
    #1;
    drive(v, rr);
    #1;
  endtask
  task automatic test_reset;
    for (int i = 0; i < NREQ; i++) begin
      ox[i] = DW'(i + 9);
      oy[i] = DW'(i + 20);
    end
    drive(4'b1111, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.mult_x !== '0 || bus.mult_y !== '0) begin errors++; $display("FAIL reset_mult got=%h/%h exp=0/0", bus.mult_x, bus.mult_y); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid); end
    checks++; if (bus.res_id !== 2'd0 || bus.res_p !== '0) begin errors++; $display("FAIL reset_res got=%0d/%h exp=0/0", bus.res_id, bus.res_p); end
`ifdef RRP_MULT_SCHED_PERF_EN
    checks++; if (issue_count !== 0 || stall_count !== 0) begin errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", issue_count, stall_count); end
`endif
    drive(4'b0000, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL idle_req_ready got=%b exp=0000", bus.req_ready); end
  endtask
  task automatic test_single;
    ox[0] = 14'h0000;
    oy[0] = 14'h0155;
    step(4'b0001, 1'b0);
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready); end
    checks++; if (bus.mult_x !== 14'h0000 || bus.mult_y !== 14'h0155) begin errors++; $display("FAIL single_mux got=%h/%h exp=0000/0155", bus.mult_x, bus.mult_y); end
    step(4'b0000, 1'b0);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_early1 got=%b exp=0", bus.res_valid); end
    step(4'b0000, 1'b0);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_early2 got=%b exp=0", bus.res_valid); end
    step(4'b0000, 1'b0);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_p !== '0) begin errors++; $display("FAIL single_result got=%b/%0d/%h exp=1/0/0", bus.res_valid, bus.res_id, bus.res_p); end
    step(4'b0000, 1'b1);
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL single_hold got=%b exp=1", bus.res_valid); end
    step(4'b0000, 1'b0);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL single_pop got=%b exp=0", bus.res_valid); end
  endtask
  task automatic test_product;
    ox[2] = 14'd3;
    oy[2] = 14'd5;
    step(4'b0100, 1'b0);
    checks++; if (bus.req_ready !== 4'b0100 || bus.mult_x !== 14'd3) begin errors++; $display("FAIL product_grant got=%b/%h exp=0100/0003", bus.req_ready, bus.mult_x); end
    repeat (3) step(4'b0000, 1'b0);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_p !== 30'd15) begin errors++; $display("FAIL product_result got=%b/%0d/%0d exp=1/2/15", bus.res_valid, bus.res_id, bus.res_p); end
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL product_pop got=%b exp=0", bus.res_valid); end
  endtask
  task automatic test_wrap;
    ox[2] = 14'h3fff;
    oy[2] = 14'h2001;
    ox[3] = 14'd9;
    oy[3] = 14'd11;
    step(4'b0100, 1'b1);
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_grant got=%b exp=0100", bus.req_ready); end
    step(4'b1111, 1'b1);
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_ptr got=%b exp=1000", bus.req_ready); end
    step(4'b0000, 1'b1);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL wrap_early got=%b exp=0", bus.res_valid); end
    step(4'b0000, 1'b1);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd2 || bus.res_p !== 30'h8001fff) begin errors++; $display("FAIL wrap_res0 got=%b/%0d/%h exp=1/2/8001fff", bus.res_valid, bus.res_id, bus.res_p); end
    step(4'b0000, 1'b1);
    checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd3 || bus.res_p !== 30'h63) begin errors++; $display("FAIL wrap_res1 got=%b/%0d/%h exp=1/3/63", bus.res_valid, bus.res_id, bus.res_p); end
    step(4'b0000, 1'b1);
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL wrap_empty got=%b exp=0", bus.res_valid); end
  endtask
  task automatic test_back_to_back;
    res_t q[$];
    res_t e;
    int got = 0;
    for (int i = 0; i < NREQ; i++) begin
      ox[i] = DW'(17 * i + 3);
      oy[i] = DW'(101 * i + 7);
    end
    for (int c = 0; c < 20; c++) begin
      step(c < 12 ? 4'b1111 : 4'b0000, 1'b1);
      if (c < 12) begin
        checks++; if (bus.req_ready !== 4'b0001 << (c % 4)) begin errors++; $display("FAIL b2b_grant c=%0d got=%b exp=%b", c, bus.req_ready, 4'b0001 << (c % 4)); end
        q.push_back('{id: 2'(c % 4), p: mp(ox[c % 4], oy[c % 4])});
      end
      if (bus.res_valid === 1'b1) begin
        got++;
        e = q.size() > 0 ? q.pop_front() : '{id: 2'd0, p: '1};
        checks++; if (bus.res_id !== e.id || bus.res_p !== e.p) begin errors++; $display("FAIL b2b_result c=%0d got=%0d/%h exp=%0d/%h", c, bus.res_id, bus.res_p, e.id, e.p); end
      end
    end
    checks++; if (got !== 12 || q.size() !== 0) begin errors++; $display("FAIL b2b_count got=%0d exp=12", got); end
  endtask
  task automatic test_backpressure;
    res_t q[$];
    res_t e;
    int got = 0;
    logic [3:0] exp_rdy;
`ifdef RRP_MULT_SCHED_PERF_EN
    logic [31:0] i0, s0;
`endif
    for (int c = 0; c < 22; c++) begin
      step(c < 12 ? 4'b1111 : 4'b0000, c >= 6);
`ifdef RRP_MULT_SCHED_PERF_EN
      if (c == 0) begin
        i0 = issue_count;
        s0 = stall_count;
      end
      if (c == 6) begin
        checks++; if (issue_count - i0 !== 32'd4 || stall_count - s0 !== 32'd2) begin errors++; $display("FAIL perf_counts got=%0d/%0d exp=4/2", issue_count - i0, stall_count - s0); end
      end
`endif
      if (c < 12) begin
        exp_rdy = c < 4 ? 4'b0001 << c : c < 6 ? 4'b0000 : 4'b0001 << ((c - 6) % 4);
        checks++; if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
        if (exp_rdy != 4'b0000) q.push_back('{id: 2'(c < 4 ? c : c - 6), p: mp(ox[c < 4 ? c : (c - 6) % 4], oy[c < 4 ? c : (c - 6) % 4])});
      end
      if (c >= 3 && c < 6) begin
        checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'd0 || bus.res_p !== mp(ox[0], oy[0])) begin errors++; $display("FAIL bp_hold c=%0d got=%b/%0d/%h exp=1/0/%h", c, bus.res_valid, bus.res_id, bus.res_p, mp(ox[0], oy[0])); end
      end
      if (c >= 6 && bus.res_valid === 1'b1) begin
        got++;
        e = q.size() > 0 ? q.pop_front() : '{id: 2'd0, p: '1};
        checks++; if (bus.res_id !== e.id || bus.res_p !== e.p) begin errors++; $display("FAIL bp_result c=%0d got=%0d/%h exp=%0d/%h", c, bus.res_id, bus.res_p, e.id, e.p); end
      end
    end
    checks++; if (got !== 10 || q.size() !== 0) begin errors++; $display("FAIL bp_count got=%0d exp=10", got); end
  endtask
  task automatic test_reset_midflight;
    step(4'b1111, 1'b0);
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant0 got=%b exp=0100", bus.req_ready); end
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    step(4'b0000, 1'b0);
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL mid_fifo got=%b exp=1", bus.res_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.res_p !== '0) begin errors++; $display("FAIL mid_async got=%b/%h exp=0/0", bus.res_valid, bus.res_p); end
`ifdef RRP_MULT_SCHED_PERF_EN
    checks++; if (issue_count !== 0 || stall_count !== 0) begin errors++; $display("FAIL mid_perf got=%0d/%0d exp=0/0", issue_count, stall_count); end
`endif
    #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step(4'b0000, 1'b0);
      checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_stale c=%0d got=%b exp=0", c, bus.res_valid); end
    end
    step(4'b0010, 1'b0);
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_restart got=%b exp=0010", bus.req_ready); end
    step(4'b0000, 1'b0);
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.res_ready = 1'b0;
    test_reset;
    test_single;
    test_product;
    test_wrap;
    test_back_to_back;
    test_backpressure;
    test_reset_midflight;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rrp_mult_sched.md
Name: rrp_mult_sched

Overview:
- Shares one rRp_mult instance (parallel online radix-r multiplier, registered inputs and outputs) between NREQ requesters.
- Round-robin arbiter with valid/ready request ports; issues at most one operand pair per cycle to the multiplier.
- Tracks in-flight operations with a tag pipeline matched to the multiplier latency.
- Returns tagged products through a credit-protected result FIFO with valid/ready backpressure, because the multiplier itself cannot stall.

Parameters:
- WIDTH, 7, digits per operand; passed through to the multiplier.
- RADIX, 2, digit radix; D = $clog2(RADIX)+1 bits per digit.
- NREQ, 4, number of requesters (2..16); IDW = max(1,$clog2(NREQ)).
- MULT_LAT, 2, clock edges from mult_x/mult_y driven to the matching mult_p valid.
- FIFO_DEPTH, 4, result FIFO entries; must be >= MULT_LAT.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_x  in  NREQ*D*WIDTH  flattened x operands; requester i at [i*D*WIDTH +: D*WIDTH].
- req_y  in  NREQ*D*WIDTH  flattened y operands, same packing.
- req_ready  out  NREQ  one-hot grant; the request is accepted when req_valid[i]&req_ready[i].
- mult_x  out  D*WIDTH  to multiplier x_in.
- mult_y  out  D*WIDTH  to multiplier y_in.
- mult_p  in  D*(2*WIDTH+1)  from multiplier p_out.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_id  out  IDW  requester index of the result.
- res_p  out  D*(2*WIDTH+1)  product digits, passed through unmodified.

Behaviour:
- Reset, asynchronous, all state cleared:
  - req_ready=0, res_valid=0, res_id=0, res_p=0, mult_x=0, mult_y=0.
  - rr_ptr=0, tag pipeline empty, FIFO empty, credits=FIFO_DEPTH.
- Credits: credits = FIFO_DEPTH − fifo_count − inflight.
  - Issue is allowed only when credits>0, so the FIFO never overflows.
  - A FIFO pop in the same cycle adds its credit back in that cycle.
- Arbitration is combinational on the current req_valid:
  - Grant the first valid requester at or after rr_ptr, in cyclic order.
  - req_ready is that one-hot grant, gated by credits>0.
  - If no requester is valid, or credits==0, req_ready=0.
- Issue cycle (a handshake occurs on requester g):
  - mult_x/mult_y take req_x/req_y of g, combinationally muxed; the multiplier registers them.
  - The tag {1,g} enters stage 0 of a MULT_LAT-deep shift register.
  - rr_ptr <= (g+1) mod NREQ.
- Idle cycles:
  - mult_x/mult_y = 0, and a tag {0,x} is shifted in.
  - rr_ptr holds.
- Tag pipeline: when the tag valid at the last stage is 1, mult_p is pushed into the FIFO together with that tag id.
  - The push is unconditional; credits guarantee there is space.
- Result FIFO:
  - First-word-fall-through; res_valid = !empty, and res_p/res_id show the head entry.
  - A pop happens when res_valid&res_ready.
  - res_p/res_id are held stable while res_valid=1 and res_ready=0.
  - Simultaneous push and pop in the same cycle is legal, and count is unchanged.
  - On an empty FIFO, a push is visible on res_valid the next cycle; no bypass.
- Latency:
  - Request accepted at edge k → result at the FIFO head after edge k+MULT_LAT.
  - res_valid goes high the cycle after that edge, provided the FIFO was empty.
  - Throughput is 1 result per cycle when res_ready=1 and FIFO_DEPTH >= MULT_LAT+1.
- Ordering:
  - Results leave in issue order.
  - Per-requester order is preserved.
- Reset during operation: in-flight tags and FIFO contents are discarded. Whatever the multiplier still produces is ignored, because all tags are invalid.
- Request-side protocol:
  - Requesters must hold req_valid and their operands stable until accepted.
  - The scheduler may withdraw req_ready without acceptance when the requester wins but credits drop to 0.

Optional Feature:
- Macro RRP_MULT_SCHED_PERF_EN.
- Defined:
  - Adds output issue_count (32 bits), incremented per accepted request.
  - Adds output stall_count (32 bits), incremented on each cycle where |req_valid and credits==0.
  - Both counters wrap at 2^32 and are cleared by reset_n.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester, RADIX=2 WIDTH=7, x=0, y arbitrary → res_valid rises 3 cycles after acceptance (MULT_LAT=2 plus FIFO); res_p=0; res_id=0.
- All 4 requesters valid continuously, res_ready=1 → grants cycle 0,1,2,3,0,…; res_id sequence 0,1,2,3,… with products matching the behavioural multiplier model.
- res_ready=0 with all requesters valid, FIFO_DEPTH=4 → exactly 4 acceptances, then req_ready=0. Raise res_ready → FIFO drains in order with no product lost, and issue resumes.
- Only requester 2 valid while rr_ptr=3 → grant wraps to 2; rr_ptr becomes 3.
- Assert reset_n low with 2 operations in flight and 1 entry in the FIFO → res_valid=0 immediately (async). After release, no stale result appears within 5 cycles.
- With RRP_MULT_SCHED_PERF_EN, run the scenario that blocks res_ready for 6 cycles → issue_count=4 and stall_count=2, or the value the model computes for the exact stimulus.
